// File: rtl/tl_tx_ur_cpl_gen.sv
// tl_tx_ur_cpl_gen: queues RX-rejected non-posted requests and streams UR/CA Completion-without-data headers
module tl_tx_ur_cpl_gen #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 err_valid,
  output logic                 err_ready,
  input  logic                 err_posted,
  input  logic [2:0]           err_status,
  input  logic [15:0]          err_req_id,
  input  logic [9:0]           err_tag,
  input  logic [2:0]           err_tc,
  input  logic [2:0]           err_attr,
  input  logic [6:0]           err_lower_addr,
  input  logic [11:0]          err_byte_count,
  input  logic [15:0]          completer_id,
  output logic                 cpl_req,
  input  logic                 cpl_grant,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [31:0]          tx_dw,
  output logic                 tx_sop,
  output logic                 tx_eop,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic                 busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, ARB, DW0, DW1, DW2} state_t;
  state_t r_state, w_next;
  logic [53:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_drop;
  logic w_push, w_pop, w_drop;
  logic [2:0] w_st_in, w_status, w_tc, w_attr;
  logic [15:0] w_req_id;
  logic [9:0] w_tag;
  logic [6:0] w_la;
  logic [11:0] w_bc;
  assign err_ready = r_cnt != FULL;
  assign w_push = err_valid & err_ready & ~err_posted;
  assign w_drop = err_valid & ~err_ready & ~err_posted;
  assign w_pop = (r_state == DW2) & tx_ready;
  assign w_st_in = (err_status == 3'b100) ? 3'b100 : 3'b001;
  assign {w_status, w_req_id, w_tag, w_tc, w_attr, w_la, w_bc} = r_mem[r_rd];
  assign cpl_req = r_state != IDLE;
  assign tx_valid = r_state inside {DW0, DW1, DW2};
  assign tx_sop = r_state == DW0;
  assign tx_eop = r_state == DW2;
  assign busy = (r_cnt != '0) | (r_state != IDLE);
  assign drop_cnt = r_drop;
  // descriptor storage; validity is tracked by r_cnt so the array needs no reset
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= {w_st_in, err_req_id, err_tag, err_tc, err_attr, err_lower_addr, err_byte_count};
  // FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_drop <= '0;
    end else begin
      r_wr   <= r_wr + AW'(w_push);
      r_rd   <= r_rd + AW'(w_pop);
      r_cnt  <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_drop <= r_drop + CNT_WIDTH'(w_drop & ~&r_drop);
    end
  end
  // FSM state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // FSM next state: arbitrate once, then the packet always runs to completion
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = (r_cnt != '0) ? ARB : IDLE;
      ARB:     w_next = cpl_grant ? DW0 : ARB;
      DW0:     w_next = tx_ready ? DW1 : DW0;
      DW1:     w_next = tx_ready ? DW2 : DW1;
      DW2:     w_next = tx_ready ? IDLE : DW2;
      default: w_next = IDLE;
    endcase
  end
  // header DW built from the FIFO head entry
  always_comb
    tx_dw = (r_state == DW0) ? {3'b000, 5'b01010, w_tag[9], w_tc, w_tag[8], w_attr[2], 2'b00, 2'b00, w_attr[1:0], 2'b00, 10'd0} :
            (r_state == DW1) ? {completer_id, w_status, 1'b0, w_bc} :
            (r_state == DW2) ? {w_req_id, w_tag[7:0], 1'b0, w_la} : 32'd0;
endmodule

// File: tb/tb_tl_tx_ur_cpl_gen.sv
// tb_tl_tx_ur_cpl_gen: randomized self-checking bench with a queue-based reference model
module tb_tl_tx_ur_cpl_gen;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] rid;
    logic [9:0]  tag;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic [6:0]  la;
    logic [11:0] bc;
  } desc_t;
  logic clk = 0, rst = 1, err_valid = 0, err_posted = 0, cpl_grant = 0, tx_ready = 0;
  logic [2:0] err_status = 0, err_tc = 0, err_attr = 0;
  logic [15:0] err_req_id = 0, completer_id = 16'h0200;
  logic [9:0] err_tag = 0;
  logic [6:0] err_lower_addr = 0;
  logic [11:0] err_byte_count = 0;
  logic err_ready, cpl_req, tx_valid, tx_sop, tx_eop, busy;
  logic [31:0] tx_dw;
  logic [7:0] drop_cnt;
  int checks = 0, errors = 0, m_drop = 0, n_push = 0, n_pop = 0, nb = 0, rb = 0, ns = 0, cyc = 0;
  desc_t exp_q[$];
  logic [33:0] beats [0:1023];
  int sop_cyc [0:1023];

  tl_tx_ur_cpl_gen #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .err_valid(err_valid), .err_ready(err_ready), .err_posted(err_posted),
    .err_status(err_status), .err_req_id(err_req_id), .err_tag(err_tag), .err_tc(err_tc),
    .err_attr(err_attr), .err_lower_addr(err_lower_addr), .err_byte_count(err_byte_count),
    .completer_id(completer_id), .cpl_req(cpl_req), .cpl_grant(cpl_grant), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_dw(tx_dw), .tx_sop(tx_sop), .tx_eop(tx_eop), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // capture every beat that will be accepted on the coming edge
  always @(negedge clk)
    if (!rst && tx_valid && tx_ready) begin
      beats[nb] = {tx_sop, tx_eop, tx_dw};
      nb = nb + 1;
      if (tx_sop) begin sop_cyc[ns] = cyc; ns = ns + 1; end
      if (tx_eop) n_pop = n_pop + 1;
    end

  // expected beat {sop, eop, dw} from the header field layout
  function automatic logic [33:0] beat_exp(desc_t e, int k);
    logic [31:0] dw;
    logic [2:0] st;
    st = (e.st == 3'd1 || e.st == 3'd4) ? e.st : 3'd1;
    if (k == 0)
      dw = 32'h0A00_0000 + (32'(e.tag[9]) << 23) + (32'(e.tc) << 20) + (32'(e.tag[8]) << 19)
         + (32'(e.attr[2]) << 18) + (32'(e.attr[1:0]) << 12);
    else if (k == 1)
      dw = 32'(completer_id) * 65536 + 32'(st) * 8192 + 32'(e.bc);
    else
      dw = 32'(e.rid) * 65536 + 32'(e.tag[7:0]) * 256 + 32'(e.la);
    return {k == 0, k == 2, dw};
  endfunction

  function automatic desc_t rand_desc();
    desc_t d;
    int r;
    r = int'($urandom % 4);
    d.st = (r == 1) ? 3'd4 : (r == 2) ? 3'($urandom) : 3'd1;
    d.rid = 16'($urandom);
    d.tag = 10'($urandom);
    d.tc = 3'($urandom);
    d.attr = 3'($urandom);
    d.la = 7'($urandom);
    d.bc = 12'($urandom);
    return d;
  endfunction

  // drive one descriptor for one cycle and update the model
  task automatic send(input logic posted, input desc_t d);
    err_valid = 1;
    err_posted = posted;
    {err_status, err_req_id, err_tag, err_tc, err_attr, err_lower_addr, err_byte_count} = d;
    if (!posted) begin
      if (n_push - n_pop < DEPTH) begin exp_q.push_back(d); n_push++; end
      else if (m_drop < 255) m_drop++;
    end
    @(posedge clk); #1;
    err_valid = 0;
    err_posted = 0;
  endtask

  task automatic wait_idle(input string nm);
    int i;
    i = 0;
    while (busy && i < 300) begin @(posedge clk); #1; i++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle_timeout busy=%b exp 0", nm, busy); end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    checks += 7;
    if (err_ready !== 1'b1) begin errors++; $display("FAIL rst_err_ready got %b exp 1", err_ready); end
    if (cpl_req !== 1'b0) begin errors++; $display("FAIL rst_cpl_req got %b exp 0", cpl_req); end
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
    if ({tx_sop, tx_eop} !== 2'b00) begin errors++; $display("FAIL rst_sop_eop got %b exp 00", {tx_sop, tx_eop}); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_cnt); end
    if (tx_dw !== 32'd0) begin errors++; $display("FAIL rst_tx_dw got %h exp 0", tx_dw); end
  endtask

  task automatic test_ur_path();
    desc_t d, e;
    logic [33:0] got;
    cpl_grant = 1;
    tx_ready = 1;
    d = '{st: 3'b001, rid: 16'h0100, tag: 10'h2A5, tc: 3'd3, attr: 3'b101, la: 7'h10, bc: 12'd4};
    send(0, d);
    checks += 4;
    if ({cpl_req, tx_valid} !== 2'b00) begin errors++; $display("FAIL ur_e0 req/valid got %b exp 00", {cpl_req, tx_valid}); end
    @(posedge clk); #1;
    if ({cpl_req, tx_valid} !== 2'b10) begin errors++; $display("FAIL ur_arb req/valid got %b exp 10", {cpl_req, tx_valid}); end
    @(posedge clk); #1;
    if ({tx_valid, tx_sop} !== 2'b11) begin errors++; $display("FAIL ur_latency valid/sop got %b exp 11", {tx_valid, tx_sop}); end
    wait_idle("ur");
    if (nb - rb !== 3) begin errors++; $display("FAIL ur_beat_count got %0d exp 3", nb - rb); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        got = (rb < nb) ? beats[rb] : 'x;
        rb++;
        if (got !== beat_exp(e, k)) begin errors++; $display("FAIL ur_beat%0d got %h exp %h", k, got, beat_exp(e, k)); end
      end
    end
  endtask

  task automatic test_backpressure();
    desc_t e;
    logic [33:0] got;
    logic [34:0] prev;
    logic pstall;
    int stalls;
    pstall = 0;
    stalls = 0;
    prev = '0;
    cpl_grant = 1;
    tx_ready = 0;
    send(0, rand_desc());
    for (int i = 0; i < 40 && busy; i++) begin
      tx_ready = (i % 2) == 1;
      if (pstall) begin
        checks++;
        stalls++;
        if ({tx_valid, tx_sop, tx_eop, tx_dw} !== prev) begin
          errors++; $display("FAIL bp_hold got %h exp %h", {tx_valid, tx_sop, tx_eop, tx_dw}, prev);
        end
      end
      pstall = tx_valid && !tx_ready;
      prev = {tx_valid, tx_sop, tx_eop, tx_dw};
      @(posedge clk); #1;
    end
    tx_ready = 1;
    wait_idle("bp");
    checks += 2;
    if (stalls == 0) begin errors++; $display("FAIL bp_stalls got 0 exp >0"); end
    if (nb - rb !== 3) begin errors++; $display("FAIL bp_beat_count got %0d exp 3", nb - rb); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        got = (rb < nb) ? beats[rb] : 'x;
        rb++;
        if (got !== beat_exp(e, k)) begin errors++; $display("FAIL bp_beat%0d got %h exp %h", k, got, beat_exp(e, k)); end
      end
    end
  endtask

  task automatic test_posted_illegal();
    desc_t d, e;
    logic [33:0] got;
    logic seen;
    seen = 0;
    cpl_grant = 1;
    tx_ready = 1;
    send(1, rand_desc());
    repeat (4) begin
      seen = seen | busy | cpl_req;
      @(posedge clk); #1;
    end
    checks += 3;
    if (seen !== 1'b0) begin errors++; $display("FAIL posted_activity got %b exp 0", seen); end
    if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL posted_drop got %0d exp %0d", drop_cnt, m_drop); end
    if (nb !== rb) begin errors++; $display("FAIL posted_beats got %0d exp 0", nb - rb); end
    d = rand_desc();
    d.st = 3'b111;
    send(0, d);
    wait_idle("illegal");
    checks++;
    got = (rb + 1 < nb) ? beats[rb + 1] : 'x;
    if (got[15:13] !== 3'b001) begin errors++; $display("FAIL illegal_status got %b exp 001", got[15:13]); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        got = (rb < nb) ? beats[rb] : 'x;
        rb++;
        if (got !== beat_exp(e, k)) begin errors++; $display("FAIL illegal_beat%0d got %h exp %h", k, got, beat_exp(e, k)); end
      end
    end
  endtask

  task automatic test_overflow();
    desc_t e;
    logic [33:0] got;
    int s0;
    cpl_grant = 0;
    tx_ready = 1;
    for (int i = 0; i < 6; i++) send(0, rand_desc());
    checks += 5;
    if (err_ready !== 1'b0) begin errors++; $display("FAIL ovf_err_ready got %b exp 0", err_ready); end
    if (drop_cnt !== 8'd2 || m_drop != 2) begin errors++; $display("FAIL ovf_drop got %0d exp 2", drop_cnt); end
    if ({cpl_req, tx_valid} !== 2'b10) begin errors++; $display("FAIL ovf_wait req/valid got %b exp 10", {cpl_req, tx_valid}); end
    s0 = ns;
    cpl_grant = 1;
    wait_idle("ovf");
    if (ns - s0 !== 4) begin errors++; $display("FAIL ovf_tlp_count got %0d exp 4", ns - s0); end
    if (ns - s0 == 4 && sop_cyc[s0 + 3] - sop_cyc[s0] !== 15) begin
      errors++; $display("FAIL ovf_sop_spacing got %0d exp 15", sop_cyc[s0 + 3] - sop_cyc[s0]);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        got = (rb < nb) ? beats[rb] : 'x;
        rb++;
        if (got !== beat_exp(e, k)) begin errors++; $display("FAIL ovf_beat%0d got %h exp %h", k, got, beat_exp(e, k)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    desc_t e;
    logic [33:0] got;
    int i;
    cpl_grant = 1;
    tx_ready = 1;
    send(0, rand_desc());
    send(0, rand_desc());
    i = 0;
    while (!(tx_valid && !tx_sop && !tx_eop) && i < 20) begin @(posedge clk); #1; i++; end
    checks++;
    if (i >= 20) begin errors++; $display("FAIL rmid_reach_dw1 timeout got %0d exp <20", i); end
    rst = 1;
    exp_q.delete();
    n_push = n_pop;
    m_drop = 0;
    @(posedge clk); #1;
    checks += 4;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_tx_valid got %b exp 0", tx_valid); end
    if (cpl_req !== 1'b0) begin errors++; $display("FAIL rmid_cpl_req got %b exp 0", cpl_req); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rmid_drop got %0d exp 0", drop_cnt); end
    rst = 0;
    rb = nb;
    send(0, rand_desc());
    wait_idle("rmid");
    checks++;
    if (nb - rb !== 3) begin errors++; $display("FAIL rmid_beat_count got %0d exp 3", nb - rb); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        got = (rb < nb) ? beats[rb] : 'x;
        rb++;
        if (got !== beat_exp(e, k)) begin errors++; $display("FAIL rmid_beat%0d got %h exp %h", k, got, beat_exp(e, k)); end
      end
    end
  endtask

  task automatic test_grant_withdraw();
    desc_t e;
    logic [33:0] got;
    int i;
    cpl_grant = 1;
    tx_ready = 1;
    send(0, rand_desc());
    i = 0;
    while (!tx_sop && i < 20) begin @(posedge clk); #1; i++; end
    @(posedge clk); #1;
    cpl_grant = 0;
    wait_idle("gw");
    repeat (2) @(posedge clk);
    #1;
    checks += 2;
    if ({cpl_req, tx_valid} !== 2'b00) begin errors++; $display("FAIL gw_idle req/valid got %b exp 00", {cpl_req, tx_valid}); end
    if (nb - rb !== 3) begin errors++; $display("FAIL gw_beat_count got %0d exp 3", nb - rb); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        got = (rb < nb) ? beats[rb] : 'x;
        rb++;
        if (got !== beat_exp(e, k)) begin errors++; $display("FAIL gw_beat%0d got %h exp %h", k, got, beat_exp(e, k)); end
      end
    end
  endtask

  task automatic test_random();
    desc_t e;
    logic [33:0] got;
    for (int i = 0; i < 60; i++) begin
      tx_ready = ($urandom % 4) != 0;
      cpl_grant = ($urandom % 3) != 0;
      if ($urandom % 2 == 1) send(($urandom % 4) == 0, rand_desc());
      else begin @(posedge clk); #1; end
    end
    tx_ready = 1;
    cpl_grant = 1;
    wait_idle("rand");
    checks += 3;
    if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL rand_drop got %0d exp %0d", drop_cnt, m_drop); end
    if (err_ready !== 1'b1) begin errors++; $display("FAIL rand_err_ready got %b exp 1", err_ready); end
    if (nb - rb !== 3 * exp_q.size()) begin errors++; $display("FAIL rand_beat_count got %0d exp %0d", nb - rb, 3 * exp_q.size()); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        got = (rb < nb) ? beats[rb] : 'x;
        rb++;
        if (got !== beat_exp(e, k)) begin errors++; $display("FAIL rand_beat%0d got %h exp %h", k, got, beat_exp(e, k)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ur_path();
    test_backpressure();
    test_posted_illegal();
    test_overflow();
    test_reset_mid();
    test_grant_withdraw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
